kamacore_dmem_responder: RTL and testbench

KAMACORE_DMEM_RESPONDER -- requirements
Module: kamacore_dmem_responder

---
 rtl/kamacore_dmem_responder.sv | 158 +++++++++++++++
 tb/tb_kamacore_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/kamacore_dmem_responder.sv
// Single-request data-memory responder for the kamacore mem stage.
// A request is accepted in IDLE, aged LATENCY cycles, serviced once, then held until handshake.
module kamacore_dmem_responder #(
  parameter int CPU_WIDTH   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [CPU_WIDTH-1:0]   req_addr,
  input  logic [CPU_WIDTH-1:0]   req_wdata,
  input  logic [CPU_WIDTH/8-1:0] req_be,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CPU_WIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = CPU_WIDTH / 8;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [CPU_WIDTH:0] ADDR_LIMIT = (CPU_WIDTH + 1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [3:0]           cnt_r, cnt_s;
  logic                 enter_resp_s;
  logic                 req_fault_s;
  logic                 we_r, fault_r;
  logic [AW-1:0]        idx_r;
  logic [CPU_WIDTH-1:0] wdata_r;
  logic [BW-1:0]        be_r;
  logic                 acc_we_s, acc_fault_s;
  logic [AW-1:0]        acc_idx_s;
  logic [CPU_WIDTH-1:0] acc_wdata_s;
  logic [BW-1:0]        acc_be_s;
  logic [CPU_WIDTH-1:0] rsp_rdata_r;
  logic                 rsp_err_r;
  logic [CPU_WIDTH-1:0] mem_r [DEPTH_WORDS];

  assign req_fault_s = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);

  // With LATENCY = 1 the access happens on the accept edge, so it must see the live request.
  always_comb begin
    acc_we_s    = we_r;
    acc_fault_s = fault_r;
    acc_idx_s   = idx_r;
    acc_wdata_s = wdata_r;
    acc_be_s    = be_r;
    if (state_r == IDLE) begin
      acc_we_s    = req_we;
      acc_fault_s = req_fault_s;
      acc_idx_s   = req_addr[AW+1:2];
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      acc_we_s    = we_r;
      acc_fault_s = fault_r;
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          cnt_s = CNT_LOAD;
          if (LATENCY == 1) begin
            state_s      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rsp_rdata_r <= {CPU_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (enter_resp_s) begin
        rsp_err_r   <= acc_fault_s;
        rsp_rdata_r <= (acc_we_s || acc_fault_s) ? {CPU_WIDTH{1'b0}} : mem_r[acc_idx_s];
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_rdata_r <= {CPU_WIDTH{1'b0}};
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && req_valid) begin
      we_r    <= req_we;
      fault_r <= req_fault_s;
      idx_r   <= req_addr[AW+1:2];
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end
  end

  // Storage write, committed only on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && enter_resp_s && acc_we_s && !acc_fault_s) begin
      for (int i = 0; i < BW; i++) begin
        if (acc_be_s[i]) begin
          mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// Directed self-checking bench: LATENCY=2 instance for function/fault/reset cases,
// LATENCY=1 instance for back-to-back throughput.
module tb_kamacore_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]  req_be1;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  kamacore_dmem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  kamacore_dmem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1), .rsp_valid(rsp_valid1),
    .rsp_ready(1'b1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the LATENCY=2 instance with rsp_ready held at 1.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic er,
                      output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        b2b [5];
  logic [31:0] got [$];
  int          got_cyc [$];

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0;
    rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 32'd0; req_wdata1 = 32'd0; req_be1 = 4'h0;

    rst = 1'b0;
    tick(); tick();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Full store then load.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st_latency", lat, 32'd2);
    check("st_err", {31'd0, er}, 32'd0);
    check("st_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check("ld_full", rd, 32'hDEADBEEF);
    check("ld_full_err", {31'd0, er}, 32'd0);

    // Partial byte enables, then an all-zero enable store.
    xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check("ld_partial", rd, 32'hDE22BE44);
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("be0_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    check("ld_after_be0", rd, 32'hDE22BE44);

    // Faults: misaligned, out of range, and an out-of-range store that must not alias word 0.
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h12, 32'd0, 4'h0, rd, er, lat);
    check("misalign_err", {31'd0, er}, 32'd1);
    check("misalign_rdata", rd, 32'd0);
    xact(1'b0, 32'h1000, 32'd0, 4'h0, rd, er, lat);
    check("range_err", {31'd0, er}, 32'd1);
    check("range_rdata", rd, 32'd0);
    xact(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat);
    check("range_st_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat);
    check("word0_kept", rd, 32'hCAFEF00D);
    xact(1'b0, 32'h0FFC, 32'd0, 4'h0, rd, er, lat);
    check("last_word_err", {31'd0, er}, 32'd0);

    // Response backpressure.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'hDE22BE44);
      check("hold_err", {31'd0, rsp_err}, 32'd0);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);
    check("post_hs_rdata", rsp_rdata, 32'd0);

    // Reset during WAIT discards the pending store.
    xact(1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (rsp_valid) seen++;
        tick();
      end
      check("wait_rst_no_rsp", seen, 32'd0);
    end
    xact(1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat);
    check("wait_rst_kept", rd, 32'h12345678);

    // Reset during RESP drops the response but keeps the committed store.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hA5A5_0F0F; req_be = 4'hF;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("resp_rst_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    xact(1'b0, 32'h24, 32'd0, 4'h0, rd, er, lat);
    check("resp_rst_committed", rd, 32'hA5A50F0F);

    // LATENCY=1 back-to-back.
    b2b[0] = '{1'b1, 32'h0, 32'h0000_1111, 32'd0};
    b2b[1] = '{1'b1, 32'h4, 32'h0000_2222, 32'd0};
    b2b[2] = '{1'b0, 32'h0, 32'd0, 32'h0000_1111};
    b2b[3] = '{1'b0, 32'h4, 32'd0, 32'h0000_2222};
    b2b[4] = '{1'b0, 32'h0, 32'd0, 32'h0000_1111};
    begin
      int idx;
      logic acc;
      idx = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        req_valid1 = (idx < 5);
        if (idx < 5) begin
          req_we1 = b2b[idx].we; req_addr1 = b2b[idx].addr;
          req_wdata1 = b2b[idx].wd; req_be1 = 4'hF;
        end
        acc = req_valid1 && req_ready1;
        if (rsp_valid1) begin
          got.push_back(rsp_rdata1);
          got_cyc.push_back(cyc);
          check("b2b_err", {31'd0, rsp_err1}, 32'd0);
        end
        tick();
        if (acc) idx++;
      end
      req_valid1 = 1'b0;
      check("b2b_accepted", idx, 32'd5);
    end
    check("b2b_count", got.size(), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      check("b2b_rdata", got[i], b2b[i].exp);
      check("b2b_cycle", got_cyc[i], 2 * i + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
